// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared core defaults and latency class constants
package reg_scoreboard_pkg;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_MAX_LAT  = 4;
  localparam int DEF_LAT_W    = 3;
  localparam int DEF_PERF_W   = 16;
  localparam int LAT_ALU      = 3;
  localparam int LAT_LOAD     = 4;
endpackage

// File: rtl/sb_popcount.sv
// sb_popcount: combinational population count of a bit vector
module sb_popcount #(
  parameter int N = 32,
  parameter int W = 6
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) count = count + W'(vec[i]);
  end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register write-back countdown scoreboard with RAW/WAW hazard
// detection, branch flush and a saturating stall counter
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_LAT  = DEF_MAX_LAT,
  parameter int LAT_W    = DEF_LAT_W,
  parameter int PERF_W   = DEF_PERF_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rs,
  input  logic [ADDR_W-1:0]   issue_rt,
  input  logic                issue_uses_rt,
  input  logic                issue_we,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic [LAT_W-1:0]    issue_lat,
  input  logic                flush,
  input  logic [LAT_W-1:0]    flush_keep,
  output logic                issue_ready,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [ADDR_W:0]     busy_count,
  output logic [PERF_W-1:0]   stall_cycles
);
  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic [LAT_W-1:0] cnt_nxt [NUM_REGS];
  logic [LAT_W-1:0] lat_eff;
  logic             accept, load, stall;
  // register 0 is hardwired idle so it can never block issue
  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < NUM_REGS; r++) busy_vec[r] = cnt[r] != '0;
  end
  assign issue_ready = ~(busy_vec[issue_rs] | (issue_uses_rt & busy_vec[issue_rt]) |
                         (issue_we & busy_vec[issue_rd]));
  assign accept  = issue_valid & issue_ready & ~flush;
  assign load    = accept & issue_we & (issue_rd != '0) & (issue_lat != '0);
  assign stall   = issue_valid & ~issue_ready & ~flush;
  assign lat_eff = (issue_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : issue_lat;
  always_comb
    for (int r = 0; r < NUM_REGS; r++)
      cnt_nxt[r] = (r == 0 || (flush && cnt[r] > flush_keep)) ? '0 :
                   (load && issue_rd == ADDR_W'(r)) ? lat_eff :
                   (cnt[r] != '0) ? cnt[r] - LAT_W'(1) : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    else for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nxt[r];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cycles <= '0;
    else if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + PERF_W'(1);
  sb_popcount #(.N(NUM_REGS), .W(ADDR_W + 1)) u_popcount (
    .vec  (busy_vec),
    .count(busy_count)
  );
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: scenario tasks with a queue of expected per-cycle results
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;
  localparam int NR = 32, AW = 5, LW = 3, PW = 4;
  logic clk = 0, rst_n = 0;
  logic issue_valid = 0, issue_uses_rt = 0, issue_we = 0, flush = 0;
  logic [AW-1:0] issue_rs = '0, issue_rt = '0, issue_rd = '0;
  logic [LW-1:0] issue_lat = '0, flush_keep = '0;
  logic issue_ready;
  logic [NR-1:0] busy_vec;
  logic [AW:0] busy_count;
  logic [PW-1:0] stall_cycles;
  int checks = 0, errors = 0;
  typedef struct {logic ready; logic [NR-1:0] busy; logic [PW-1:0] stall;} exp_t;
  exp_t q[$];
  exp_t e;

  reg_scoreboard #(.PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rs(issue_rs),
    .issue_rt(issue_rt), .issue_uses_rt(issue_uses_rt), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .flush(flush), .flush_keep(flush_keep),
    .issue_ready(issue_ready), .busy_vec(busy_vec), .busy_count(busy_count),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int rs, input int rt, input logic urt,
                       input logic we, input int rd, input int lat, input logic fl, input int keep);
    issue_valid = v; issue_rs = AW'(rs); issue_rt = AW'(rt); issue_uses_rt = urt;
    issue_we = we; issue_rd = AW'(rd); issue_lat = LW'(lat); flush = fl; flush_keep = LW'(keep);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    rst_n = 0;
    idle();
    cyc();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive(1, 3, 4, 1, 1, 3, 2, 0, 0);
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL reset_busy: got %h exp 0", busy_vec); end
    checks++; if (busy_count !== '0) begin errors++; $display("FAIL reset_count: got %0d exp 0", busy_count); end
    checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL reset_stall: got %0d exp 0", stall_cycles); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", issue_ready); end
    cyc();
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL reset_hold_busy: got %h exp 0", busy_vec); end
    rst_n = 1;
    idle();
  endtask

  task automatic test_raw();
    apply_reset();
    drive(1, 1, 2, 0, 1, 8, LAT_ALU, 0, 0);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_first_ready: got %b exp 1", issue_ready); end
    cyc();
    for (int i = 0; i < 4; i++) begin
      e.ready = (i == 3);
      e.busy  = (i < 3) ? NR'(32'h100) : '0;
      e.stall = PW'(i);
      q.push_back(e);
    end
    drive(1, 8, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      e = q.pop_front();
      checks++; if (issue_ready !== e.ready) begin errors++; $display("FAIL raw_ready[%0d]: got %b exp %b", i, issue_ready, e.ready); end
      checks++; if (busy_vec !== e.busy) begin errors++; $display("FAIL raw_busy[%0d]: got %h exp %h", i, busy_vec, e.busy); end
      checks++; if (stall_cycles !== e.stall) begin errors++; $display("FAIL raw_stall[%0d]: got %0d exp %0d", i, stall_cycles, e.stall); end
      cyc();
    end
    idle();
    checks++; if (stall_cycles !== PW'(3)) begin errors++; $display("FAIL raw_stall_total: got %0d exp 3", stall_cycles); end
  endtask

  task automatic test_sources();
    apply_reset();
    drive(1, 0, 0, 0, 1, 8, 2, 0, 0);
    cyc();
    drive(1, 1, 8, 0, 0, 0, 0, 0, 0);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rt_unused: got %b exp 1", issue_ready); end
    drive(1, 1, 8, 1, 0, 0, 0, 0, 0);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL rt_hazard: got %b exp 0", issue_ready); end
    drive(1, 1, 2, 0, 1, 8, 2, 0, 0);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL waw_hazard: got %b exp 0", issue_ready); end
    drive(1, 1, 2, 1, 1, 9, 2, 0, 0);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL no_hazard: got %b exp 1", issue_ready); end
    drive(1, 8, 0, 0, 0, 0, 0, 1, 7);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_path: got %b exp 0", issue_ready); end
    cyc();
    idle();
    checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL flush_no_stall: got %0d exp 0", stall_cycles); end
    checks++; if (busy_vec !== NR'(32'h100)) begin errors++; $display("FAIL flush_keep_all: got %h exp 100", busy_vec); end
  endtask

  task automatic test_zero();
    apply_reset();
    drive(1, 0, 0, 0, 1, 0, 4, 0, 0);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL r0_ready: got %b exp 1", issue_ready); end
    cyc();
    drive(1, 0, 0, 1, 1, 7, 0, 0, 0);
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL r0_busy: got %h exp 0", busy_vec); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL r0_rs_ready: got %b exp 1", issue_ready); end
    cyc();
    idle();
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL lat0_busy: got %h exp 0", busy_vec); end
    checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL r0_stall: got %0d exp 0", stall_cycles); end
  endtask

  task automatic test_clamp();
    apply_reset();
    drive(1, 0, 0, 0, 1, 10, 7, 0, 0);
    cyc();
    for (int i = 0; i < 6; i++) begin
      e.ready = 1'b1;
      e.busy  = (i < DEF_MAX_LAT) ? NR'(32'h400) : '0;
      e.stall = '0;
      q.push_back(e);
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      e = q.pop_front();
      checks++; if (busy_vec !== e.busy) begin errors++; $display("FAIL clamp_busy[%0d]: got %h exp %h", i, busy_vec, e.busy); end
      cyc();
    end
  endtask

  task automatic test_flush();
    apply_reset();
    drive(1, 0, 0, 0, 1, 7, 3, 0, 0);
    cyc();
    drive(1, 0, 0, 0, 1, 5, 4, 0, 0);
    cyc();
    drive(1, 0, 0, 0, 1, 6, 2, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 2);
    checks++; if (busy_count !== 6'd3) begin errors++; $display("FAIL flush_pre_count: got %0d exp 3", busy_count); end
    cyc();
    idle();
    checks++; if (busy_vec !== NR'(32'h40)) begin errors++; $display("FAIL flush_busy: got %h exp 40", busy_vec); end
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL flush_count: got %0d exp 1", busy_count); end
    cyc();
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL flush_drain_count: got %0d exp 0", busy_count); end
  endtask

  task automatic test_flush_issue();
    apply_reset();
    drive(1, 0, 0, 0, 1, 9, 2, 1, 0);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL flush_issue_ready: got %b exp 1", issue_ready); end
    cyc();
    idle();
    checks++; if (busy_vec[9] !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b exp 0", busy_vec[9]); end
    cyc();
    checks++; if (busy_vec[9] !== 1'b0) begin errors++; $display("FAIL flush_not_deferred: got %b exp 0", busy_vec[9]); end
  endtask

  task automatic test_saturate();
    int n;
    apply_reset();
    for (int i = 0; i < 25; i++) begin
      n = i - (i + 4) / 5;
      e.ready = (i % 5 == 0);
      e.busy  = '0;
      e.stall = PW'((n > 15) ? 15 : n);
      q.push_back(e);
    end
    drive(1, 12, 0, 0, 1, 12, LAT_LOAD, 0, 0);
    for (int i = 0; i < 25; i++) begin
      e = q.pop_front();
      checks++; if (issue_ready !== e.ready) begin errors++; $display("FAIL sat_ready[%0d]: got %b exp %b", i, issue_ready, e.ready); end
      checks++; if (stall_cycles !== e.stall) begin errors++; $display("FAIL sat_stall[%0d]: got %0d exp %0d", i, stall_cycles, e.stall); end
      cyc();
    end
    idle();
    checks++; if (stall_cycles !== PW'(15)) begin errors++; $display("FAIL sat_final: got %0d exp 15", stall_cycles); end
  endtask

  task automatic test_midflight_reset();
    apply_reset();
    drive(1, 0, 0, 0, 1, 3, 4, 0, 0);
    cyc();
    drive(1, 0, 0, 0, 1, 4, 4, 0, 0);
    cyc();
    drive(1, 0, 0, 0, 1, 5, 4, 0, 0);
    cyc();
    drive(1, 3, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (busy_count !== 6'd3) begin errors++; $display("FAIL mid_pre_count: got %0d exp 3", busy_count); end
    rst_n = 0;
    #1;
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL mid_busy: got %h exp 0", busy_vec); end
    checks++; if (busy_count !== '0) begin errors++; $display("FAIL mid_count: got %0d exp 0", busy_count); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b exp 1", issue_ready); end
    cyc();
    rst_n = 1;
    drive(1, 0, 0, 0, 1, 3, 2, 0, 0);
    cyc();
    idle();
    checks++; if (busy_vec !== NR'(32'h8)) begin errors++; $display("FAIL mid_first_accept: got %h exp 8", busy_vec); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_sources();
    test_zero();
    test_clamp();
    test_flush();
    test_flush_issue();
    test_saturate();
    test_midflight_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
